// File: rtl/max_pool_pkg.sv
// Shared types and helpers for the max-pool gradient router.
package max_pool_pkg;

  localparam int DATA_W = 16;

  // Signed fixed-point data word used on the pixel and gradient streams.
  typedef logic signed [DATA_W-1:0] data_t;

  // Pass phases: forward capture, gradient load, input-gradient emit.
  typedef enum logic [1:0] {
    S_FWD   = 2'd0,
    S_GLOAD = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  // Bits needed for a position inside a STRIDE x STRIDE window, at least 1.
  function automatic int idx_width(input int stride);
    int w;
    w = 1;
    while ((1 << w) < stride * stride) w++;
    return w;
  endfunction

endpackage

// File: rtl/max_pool_grad_router_tracker.sv
// Running argmax per window column. One window row is in flight at a time,
// so a single register per pooled column is enough.
module pool_argmax_tracker #(
  parameter int WIDTH = 16,
  parameter int WINS  = 2,
  parameter int IDX_W = 2,
  parameter int COL_W = 1
) (
  input  logic                    clk,
  input  logic                    pix_en,
  input  logic                    win_first,
  input  logic                    win_last,
  input  logic [COL_W-1:0]        col,
  input  logic [IDX_W-1:0]        local_idx,
  input  logic signed [WIDTH-1:0] data,
  output logic                    done,
  output logic [IDX_W-1:0]        done_idx
);

  logic signed [WIDTH-1:0] run_max [WINS];
  logic [IDX_W-1:0]        run_idx [WINS];
  logic                    take;

  // First pixel always loads; later pixels replace only on strictly greater,
  // so ties keep the earliest raster position.
  always_comb begin
    take     = win_first || (data > run_max[col]);
    done     = pix_en && win_last;
    done_idx = take ? local_idx : run_idx[col];
  end

  // Update the running max/idx for the window column of the accepted pixel.
  always_ff @(posedge clk) begin
    if (pix_en && take) begin
      run_max[col] <= data;
      run_idx[col] <= local_idx;
    end
  end

endmodule

// File: rtl/max_pool_grad_router.sv
// Backward-pass router for max pooling: captures per-window argmax from the
// forward pixel stream, loads one gradient per window, then emits the input
// gradient in raster order with each gradient placed at its argmax.
//
// Handshakes: every stream transfers on a rising clk edge when valid && ready.
// fwd_ready and grad_in_ready depend only on state; grad_out_valid/data/last
// are registered and held unchanged while grad_out_valid && !grad_out_ready.
module max_pool_grad_router
  import max_pool_pkg::*;
#(
  parameter int WIDTH             = 16,
  parameter int STRIDE            = 2,
  parameter int INPUT_DIM_WIDTH   = 4,
  parameter int INPUT_DIM_HEIGHT  = 4,
  parameter int OUTPUT_DIM_WIDTH  = INPUT_DIM_WIDTH / STRIDE,
  parameter int OUTPUT_DIM_HEIGHT = INPUT_DIM_HEIGHT / STRIDE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fwd_valid,
  output logic                    fwd_ready,
  input  logic signed [WIDTH-1:0] fwd_data,
  input  logic                    grad_in_valid,
  output logic                    grad_in_ready,
  input  logic signed [WIDTH-1:0] grad_in_data,
  output logic                    grad_out_valid,
  input  logic                    grad_out_ready,
  output logic signed [WIDTH-1:0] grad_out_data,
  output logic                    grad_out_last,
  output state_t                  dbg_state
);

  localparam int H     = INPUT_DIM_HEIGHT;
  localparam int W     = INPUT_DIM_WIDTH;
  localparam int OH    = OUTPUT_DIM_HEIGHT;
  localparam int OW    = OUTPUT_DIM_WIDTH;
  localparam int NWIN  = OH * OW;
  localparam int IDX_W = idx_width(STRIDE);
  localparam int RW    = (H > 1) ? $clog2(H) : 1;
  localparam int CW    = (W > 1) ? $clog2(W) : 1;
  localparam int WW    = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int OCW   = (OW > 1) ? $clog2(OW) : 1;

  state_t          state;
  logic [RW-1:0]   r, nr, pr;
  logic [CW-1:0]   c, nc, pc;
  logic [WW-1:0]   k;
  logic            at_end;

  // Forward-pixel decode of the current (r, c).
  logic             f_in, f_first, f_last;
  logic [IDX_W-1:0] f_local;
  logic [OCW-1:0]   f_col;
  logic [WW-1:0]    f_win;

  // Emit decode of the element about to be presented.
  logic                    e_in, e_last;
  logic [IDX_W-1:0]        e_local;
  logic [WW-1:0]           e_win;
  logic signed [WIDTH-1:0] e_grad, e_data;

  logic             trk_done;
  logic [IDX_W-1:0] trk_idx;

  logic [IDX_W-1:0]        idx_buf  [NWIN];
  logic signed [WIDTH-1:0] grad_buf [NWIN];

  assign dbg_state     = state;
  assign fwd_ready     = (state == S_FWD);
  assign grad_in_ready = (state == S_GLOAD);

  // Window geometry of the forward pixel at (r, c) and the raster successor.
  always_comb begin
    int ri, ci;
    ri      = int'(r);
    ci      = int'(c);
    f_in    = (ri < OH * STRIDE) && (ci < OW * STRIDE);
    f_local = IDX_W'((ri % STRIDE) * STRIDE + (ci % STRIDE));
    f_first = ((ri % STRIDE) == 0) && ((ci % STRIDE) == 0);
    f_last  = ((ri % STRIDE) == STRIDE - 1) && ((ci % STRIDE) == STRIDE - 1);
    f_col   = OCW'(ci / STRIDE);
    f_win   = WW'((ri / STRIDE) * OW + ci / STRIDE);
    at_end  = (ri == H - 1) && (ci == W - 1);
    if (ci == W - 1) begin
      nc = '0;
      nr = r + 1'b1;
    end else begin
      nc = c + 1'b1;
      nr = r;
    end
  end

  // Output value for the next element to present: (0,0) when entering emit,
  // else the raster successor. A one-window map needs the gradient arriving
  // this cycle, so it bypasses grad_buf.
  always_comb begin
    int pi, pci;
    pr      = (state == S_EMIT) ? nr : '0;
    pc      = (state == S_EMIT) ? nc : '0;
    pi      = int'(pr);
    pci     = int'(pc);
    e_in    = (pi < OH * STRIDE) && (pci < OW * STRIDE);
    e_local = IDX_W'((pi % STRIDE) * STRIDE + (pci % STRIDE));
    e_win   = WW'((pi / STRIDE) * OW + pci / STRIDE);
    e_last  = (pi == H - 1) && (pci == W - 1);
    e_grad  = (state == S_GLOAD && e_win == k) ? grad_in_data : grad_buf[e_win];
    e_data  = (e_in && e_local == idx_buf[e_win]) ? e_grad : '0;
  end

  pool_argmax_tracker #(
    .WIDTH (WIDTH),
    .WINS  (OW),
    .IDX_W (IDX_W),
    .COL_W (OCW)
  ) u_tracker (
    .clk       (clk),
    .pix_en    ((state == S_FWD) && fwd_valid && f_in),
    .win_first (f_first),
    .win_last  (f_last),
    .col       (f_col),
    .local_idx (f_local),
    .data      (fwd_data),
    .done      (trk_done),
    .done_idx  (trk_idx)
  );

  // Argmax and gradient storage; written before read within each pass.
  always_ff @(posedge clk) begin
    if (trk_done) idx_buf[f_win] <= trk_idx;
    if (state == S_GLOAD && grad_in_valid) grad_buf[k] <= grad_in_data;
  end

  // Phase sequencing, raster counters and registered output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_FWD;
      r              <= '0;
      c              <= '0;
      k              <= '0;
      grad_out_valid <= 1'b0;
      grad_out_data  <= '0;
      grad_out_last  <= 1'b0;
    end else begin
      case (state)
        S_FWD: begin
          if (fwd_valid) begin
            if (at_end) begin
              r     <= '0;
              c     <= '0;
              k     <= '0;
              state <= S_GLOAD;
            end else begin
              r <= nr;
              c <= nc;
            end
          end
        end
        S_GLOAD: begin
          if (grad_in_valid) begin
            if (int'(k) == NWIN - 1) begin
              state          <= S_EMIT;
              r              <= '0;
              c              <= '0;
              grad_out_valid <= 1'b1;
              grad_out_data  <= e_data;
              grad_out_last  <= e_last;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (grad_out_ready) begin
            if (grad_out_last) begin
              state          <= S_FWD;
              r              <= '0;
              c              <= '0;
              grad_out_valid <= 1'b0;
              grad_out_data  <= '0;
              grad_out_last  <= 1'b0;
            end else begin
              r             <= nr;
              c             <= nc;
              grad_out_data <= e_data;
              grad_out_last <= e_last;
            end
          end
        end
        default: state <= S_FWD;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_grad_router.sv
// Bench for max_pool_grad_router: a 2x2-map instance and a 4x4-map instance
// share one driver set; sel picks which one is being exercised.
`timescale 1ns/1ps
module tb_max_pool_grad_router;
  import max_pool_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared drive and muxed views ----------------
  logic                sel;
  logic                fwd_valid, grad_in_valid, grad_out_ready;
  logic signed [W-1:0] fwd_data, grad_in_data;

  logic a_fwd_ready, a_gi_ready, a_go_valid, a_go_last;
  logic b_fwd_ready, b_gi_ready, b_go_valid, b_go_last;
  logic signed [W-1:0] a_go_data, b_go_data;
  state_t a_state, b_state;

  logic fwd_ready, grad_in_ready, grad_out_valid, grad_out_last;
  logic signed [W-1:0] grad_out_data;
  state_t dut_state;

  assign fwd_ready      = sel ? b_fwd_ready : a_fwd_ready;
  assign grad_in_ready  = sel ? b_gi_ready  : a_gi_ready;
  assign grad_out_valid = sel ? b_go_valid  : a_go_valid;
  assign grad_out_last  = sel ? b_go_last   : a_go_last;
  assign grad_out_data  = sel ? b_go_data   : a_go_data;
  assign dut_state      = sel ? b_state     : a_state;

  max_pool_grad_router #(.WIDTH(W), .STRIDE(2), .INPUT_DIM_WIDTH(2), .INPUT_DIM_HEIGHT(2)) u_a (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid && !sel), .fwd_ready(a_fwd_ready), .fwd_data(fwd_data),
    .grad_in_valid(grad_in_valid && !sel), .grad_in_ready(a_gi_ready), .grad_in_data(grad_in_data),
    .grad_out_valid(a_go_valid), .grad_out_ready(grad_out_ready && !sel),
    .grad_out_data(a_go_data), .grad_out_last(a_go_last), .dbg_state(a_state)
  );

  max_pool_grad_router #(.WIDTH(W), .STRIDE(2), .INPUT_DIM_WIDTH(4), .INPUT_DIM_HEIGHT(4)) u_b (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid && sel), .fwd_ready(b_fwd_ready), .fwd_data(fwd_data),
    .grad_in_valid(grad_in_valid && sel), .grad_in_ready(b_gi_ready), .grad_in_data(grad_in_data),
    .grad_out_valid(b_go_valid), .grad_out_ready(grad_out_ready && sel),
    .grad_out_data(b_go_data), .grad_out_last(b_go_last), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [W:0]          exp_q[$];   // {last, data}
  logic signed [W-1:0] pix_q[$];
  logic signed [W-1:0] grad_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", tag, $time);
  endtask

  // Reference: argmax per 2x2 window (strict >, earliest wins), then raster
  // order output with the window gradient at its argmax, zero elsewhere.
  task automatic build_expected(input int h, input int w);
    int oh, ow, bi;
    int best_r[16];
    int best_c[16];
    logic signed [W-1:0] best_v, v, val;
    oh = h / 2;
    ow = w / 2;
    for (int wr = 0; wr < oh; wr++) begin
      for (int wc = 0; wc < ow; wc++) begin
        bi = wr * ow + wc;
        best_r[bi] = wr * 2;
        best_c[bi] = wc * 2;
        best_v = pix_q[(wr * 2) * w + wc * 2];
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            v = pix_q[(wr * 2 + dr) * w + wc * 2 + dc];
            if (v > best_v) begin
              best_v = v;
              best_r[bi] = wr * 2 + dr;
              best_c[bi] = wc * 2 + dc;
            end
          end
        end
      end
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        bi  = (r / 2) * ow + c / 2;
        val = (r == best_r[bi] && c == best_c[bi]) ? grad_q[bi] : '0;
        exp_q.push_back({(r == h - 1 && c == w - 1), val});
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_fwd(input bit rnd);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < pix_q.size()) begin
      @(negedge clk);
      fwd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fwd_data  = pix_q[i];
      if (fwd_valid && fwd_ready) i++;
      guard++;
      if (guard > 2000) begin
        timeout_fail("fwd_accept");
        break;
      end
    end
    @(negedge clk);
    fwd_valid = 1'b0;
  endtask

  task automatic drive_grad(input bit rnd);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < grad_q.size()) begin
      @(negedge clk);
      grad_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      grad_in_data  = grad_q[i];
      if (grad_in_valid && grad_in_ready) begin
        i++;
        if (i == grad_q.size()) check_eq("out_valid_before_last_grad", 32'(grad_out_valid), 32'd0);
      end
      guard++;
      if (guard > 2000) begin
        timeout_fail("grad_accept");
        break;
      end
    end
    @(negedge clk);
    grad_in_valid = 1'b0;
    check_eq("out_valid_latency", 32'(grad_out_valid), 32'd1);
  endtask

  // Pops one expected element per output handshake; while stalled the held
  // output is compared against the same pending expectation.
  task automatic collect(input bit bp, input int cnt);
    int n, guard;
    bit tog;
    n = 0;
    guard = 0;
    tog = 1'b1;
    while (n < cnt) begin
      @(negedge clk);
      grad_out_ready = bp ? tog : 1'b1;
      tog = ~tog;
      if (grad_out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("out_unexpected", {15'd0, grad_out_last, grad_out_data}, 32'h1ffff);
          break;
        end
        check_eq(grad_out_ready ? "out_elem" : "out_held", {15'd0, grad_out_last, grad_out_data},
                 {15'd0, exp_q[0]});
        if (grad_out_ready) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      guard++;
      if (guard > 2000) begin
        timeout_fail("grad_out");
        break;
      end
    end
    @(negedge clk);
    grad_out_ready = 1'b0;
  endtask

  task automatic run_pass(input logic s, input bit rnd, input bit bp);
    int h;
    sel = s;
    h = s ? 4 : 2;
    build_expected(h, h);
    drive_fwd(rnd);
    drive_grad(rnd);
    collect(bp, h * h);
    check_eq("end_state", 32'(dut_state), 32'(S_FWD));
    check_eq("end_fwd_ready", 32'(fwd_ready), 32'd1);
    check_eq("end_out_valid", 32'(grad_out_valid), 32'd0);
    check_eq("end_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_map(input int vals[], input int grads[]);
    pix_q.delete();
    grad_q.delete();
    foreach (vals[i]) pix_q.push_back(W'(vals[i]));
    foreach (grads[i]) grad_q.push_back(W'(grads[i]));
  endtask

  task automatic load_random(input int npix, input int ngrad);
    int t;
    pix_q.delete();
    grad_q.delete();
    for (int i = 0; i < npix; i++) begin
      t = $urandom_range(0, 15) - 8;
      pix_q.push_back(W'(t));
    end
    for (int i = 0; i < ngrad; i++) begin
      t = $urandom_range(0, 65535);
      grad_q.push_back(W'(t));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    sel = 1'b0;
    fwd_valid = 1'b0;
    grad_in_valid = 1'b0;
    grad_out_ready = 1'b0;
    fwd_data = '0;
    grad_in_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_a_fwd_ready", 32'(a_fwd_ready), 32'd1);
    check_eq("rst_a_gi_ready", 32'(a_gi_ready), 32'd0);
    check_eq("rst_a_out", {14'd0, a_go_valid, a_go_last, a_go_data}, 32'd0);
    check_eq("rst_b_fwd_ready", 32'(b_fwd_ready), 32'd1);
    check_eq("rst_b_gi_ready", 32'(b_gi_ready), 32'd0);
    check_eq("rst_b_out", {14'd0, b_go_valid, b_go_last, b_go_data}, 32'd0);
    check_eq("rst_b_state", 32'(b_state), 32'(S_FWD));
    rst = 1'b0;
    @(negedge clk);

    // 2x2 basic: max at last position
    load_map('{1, 3, 2, 4}, '{8});
    run_pass(1'b0, 1'b0, 1'b0);

    // 4x4 example with a tie in window 1 and negatives in window 3
    load_map('{1, 5, 2, 0, 3, 2, 9, 9, 7, 0, -1, -2, 0, 8, -3, -4}, '{10, 20, 30, 40});
    run_pass(1'b1, 1'b0, 1'b0);

    // ties keep earliest; all-negative window
    load_map('{5, 5, 5, 5}, '{-6});
    run_pass(1'b0, 1'b0, 1'b0);
    load_map('{-1, -3, -2, -4}, '{7});
    run_pass(1'b0, 1'b0, 1'b0);

    // random data with input gaps and 1010 output backpressure, back to back
    for (int p = 0; p < 3; p++) begin
      load_random(16, 4);
      run_pass(1'b1, 1'b1, 1'b1);
    end
    load_random(4, 1);
    run_pass(1'b0, 1'b1, 1'b1);

    // reset during emit after two elements
    sel = 1'b0;
    load_map('{2, 9, 1, 0}, '{5});
    build_expected(2, 2);
    drive_fwd(1'b0);
    drive_grad(1'b0);
    collect(1'b0, 2);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_out", {14'd0, grad_out_valid, grad_out_last, grad_out_data}, 32'd0);
    check_eq("midrst_state", 32'(dut_state), 32'(S_FWD));
    check_eq("midrst_fwd_ready", 32'(fwd_ready), 32'd1);
    check_eq("midrst_gi_ready", 32'(grad_in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_map('{4, 1, 1, 1}, '{3});
    run_pass(1'b0, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard stop if the sequence itself wedges.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d checks=%0d)", n_err, n_checks);
    $fatal(1);
  end

endmodule
